// File: rtl/fifo_write_ctrl.sv
// Async FIFO write side: binary/Gray write pointer, 2-flop read-pointer sync, FULL/level/OVERFLOW.
// Write-to-pointer latency 1 cycle, read-to-full 2 cycles; writes while FULL are dropped and flagged.
module fifo_write_ctrl #(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH):0]     rd_ptr_gray,
    output logic [$clog2(DEPTH):0]     wr_ptr,
    output logic [$clog2(DEPTH):0]     wr_ptr_gray,
    output logic [$clog2(DEPTH)-1:0]   wr_addr,
    output logic                       mem_we,
    output logic                       FULL,
    output logic                       ALMOST_FULL,
    output logic [$clog2(DEPTH):0]     wr_level,
    output logic                       OVERFLOW
);
    localparam int PB = $clog2(DEPTH);
    localparam logic [PB:0] AFULL_THR = (PB+1)'(AFULL_LEVEL);

    logic [PB:0] wr_ptr_q, wr_ptr_d;
    logic [PB:0] wr_gray_q, wr_gray_d;
    logic [PB:0] rd_sync1_q, rd_sync2_q;
    logic [PB:0] rd_ptr_wrclk;
    logic        overflow_q, overflow_d;
    logic        full;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        rd_ptr_wrclk = '0;
        for (int i = 0; i <= PB; i++) begin
            rd_ptr_wrclk[i] = ^(rd_sync2_q >> i);
        end
    end

    assign full = (wr_ptr_q[PB] != rd_ptr_wrclk[PB]) &&
                  (wr_ptr_q[PB-1:0] == rd_ptr_wrclk[PB-1:0]);

    assign mem_we = wr_rst_n & wr_en & ~full;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_gray_d  = wr_gray_q;
        overflow_d = overflow_q | (wr_en & full);
        if (mem_we) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            wr_gray_d = wr_ptr_d ^ (wr_ptr_d >> 1);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (!wr_rst_n) begin
            wr_ptr_q   <= '0;
            wr_gray_q  <= '0;
            rd_sync1_q <= '0;
            rd_sync2_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wr_gray_q  <= wr_gray_d;
            rd_sync1_q <= rd_ptr_gray;
            rd_sync2_q <= rd_sync1_q;
            overflow_q <= overflow_d;
        end
    end

    assign wr_ptr      = wr_ptr_q;
    assign wr_ptr_gray = wr_gray_q;
    assign wr_addr     = wr_ptr_q[PB-1:0];
    assign FULL        = full;
    assign wr_level    = wr_ptr_q - rd_ptr_wrclk;
    assign ALMOST_FULL = (wr_level >= AFULL_THR);
    assign OVERFLOW    = overflow_q;

endmodule
